// File: rtl/contador_bcd_updown_if.sv
// contador_bcd_updown_if: bundles the button inputs, the four BCD digits and the carry pulse.
//   BtnUp, BtnDown           debounced button levels, 1 = pressed
//   unidades..unidadesMillar BCD digits, units to thousands
//   Carry                    one-clock pulse on wrap or on a step blocked at a limit
//   master: button source / display side; slave: the counter
interface contador_bcd_updown_if;
  logic       BtnUp;
  logic       BtnDown;
  logic [3:0] unidades;
  logic [3:0] decenas;
  logic [3:0] centenas;
  logic [3:0] unidadesMillar;
  logic       Carry;
  modport master (output BtnUp, BtnDown, input unidades, decenas, centenas, unidadesMillar, Carry);
  modport slave  (input BtnUp, BtnDown, output unidades, decenas, centenas, unidadesMillar, Carry);
endinterface

// File: rtl/contador_bcd_updown.sv
// contador_bcd_updown: four-digit BCD up/down counter with press stepping and hold auto-repeat.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of contador_bcd_updown_if (buttons in, digits and Carry out)
module contador_bcd_updown #(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned WRAP          = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  contador_bcd_updown_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HOLD_UP, HOLD_DN, REPEAT_UP, REPEAT_DN, BLOCK} state_t;
  state_t          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d, lim;
  logic            up_prev_q, dn_prev_q, carry_q, carry_d;
  logic [3:0][3:0] dig_q, dig_d, inc, dec;
  logic            press_up, press_dn, is_up, own, oth, step_up, step_dn, cu, cd;
  assign press_up = bus.BtnUp & ~up_prev_q;
  assign press_dn = bus.BtnDown & ~dn_prev_q;
  assign is_up    = (state_q == HOLD_UP) || (state_q == REPEAT_UP);
  // own: the button that started the hold; oth: the opposite one
  assign own      = is_up ? bus.BtnUp : bus.BtnDown;
  assign oth      = is_up ? bus.BtnDown : bus.BtnUp;
  assign lim      = (state_q == HOLD_UP || state_q == HOLD_DN) ? HOLD_CYCLES - 1 : REPEAT_CYCLES - 1;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    case (state_q)
      IDLE:
        if ((press_up || press_dn) && bus.BtnUp && bus.BtnDown) state_d = BLOCK;
        else if (press_up) begin
          step_up = 1'b1;
          state_d = HOLD_UP;
        end else if (press_dn) begin
          step_dn = 1'b1;
          state_d = HOLD_DN;
        end
      HOLD_UP, HOLD_DN, REPEAT_UP, REPEAT_DN:
        if (!own || oth) begin
          state_d = own ? BLOCK : IDLE;
          cnt_d   = '0;
        end else if (cnt_q == lim) begin
          cnt_d   = '0;
          state_d = is_up ? REPEAT_UP : REPEAT_DN;
          step_up = is_up;
          step_dn = !is_up;
        end else cnt_d = cnt_q + 32'd1;
      BLOCK:
        if (!bus.BtnUp && !bus.BtnDown) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      default: state_d = IDLE;
    endcase
  end
  // Ripple +1/-1 across digits; the final carry/borrow flags 9999 / 0000
  always_comb begin
    inc = dig_q;
    dec = dig_q;
    cu  = 1'b1;
    cd  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (cu) begin
        inc[i] = dig_q[i] == 4'd9 ? 4'd0 : dig_q[i] + 4'd1;
        cu     = dig_q[i] == 4'd9;
      end
      if (cd) begin
        dec[i] = dig_q[i] == 4'd0 ? 4'd9 : dig_q[i] - 4'd1;
        cd     = dig_q[i] == 4'd0;
      end
    end
    carry_d = (step_up & cu) | (step_dn & cd);
    dig_d   = (carry_d && WRAP == 0) ? dig_q : step_up ? inc : step_dn ? dec : dig_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      up_prev_q <= 1'b0;
      dn_prev_q <= 1'b0;
      carry_q   <= 1'b0;
      dig_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      up_prev_q <= bus.BtnUp;
      dn_prev_q <= bus.BtnDown;
      carry_q   <= carry_d;
      dig_q     <= dig_d;
    end
  end
  assign bus.unidades       = dig_q[0];
  assign bus.decenas        = dig_q[1];
  assign bus.centenas       = dig_q[2];
  assign bus.unidadesMillar = dig_q[3];
  assign bus.Carry          = carry_q;
endmodule

// File: tb/tb_contador_bcd_updown.sv
// tb_contador_bcd_updown: directed checks of a wrapping and a saturating counter instance.
module tb_contador_bcd_updown;
  logic clk = 1'b0, rst_n = 1'b0, bu = 1'b0, bd = 1'b0, sel = 1'b0;
  int   tests = 0, fails = 0;
  always #5 clk = ~clk;
  contador_bcd_updown_if bw ();
  contador_bcd_updown_if bs ();
  assign bw.BtnUp   = bu & ~sel;
  assign bw.BtnDown = bd & ~sel;
  assign bs.BtnUp   = bu & sel;
  assign bs.BtnDown = bd & sel;
  contador_bcd_updown #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4), .WRAP(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bw.slave));
  contador_bcd_updown #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4), .WRAP(0)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(bs.slave));
  function automatic logic [15:0] cnt();
    return sel ? {bs.unidadesMillar, bs.centenas, bs.decenas, bs.unidades}
               : {bw.unidadesMillar, bw.centenas, bw.decenas, bw.unidades};
  endfunction
  function automatic logic car();
    return sel ? bs.Carry : bw.Carry;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bu = 1'b0;
    bd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic press(input logic up, output logic c1, output logic c2);
    @(negedge clk);
    if (up) bu = 1'b1; else bd = 1'b1;
    @(negedge clk);
    c1 = car();
    bu = 1'b0;
    bd = 1'b0;
    @(negedge clk);
    c2 = car();
  endtask
  task automatic hold_to(input logic up, input logic [15:0] tgt, input int budget, output logic ok);
    ok = 1'b0;
    @(negedge clk);
    if (up) bu = 1'b1; else bd = 1'b1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (cnt() == tgt) ok = 1'b1;
    end
    bu = 1'b0;
    bd = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      tests++;
      if (cnt() !== 16'h0000 || car() !== 1'b0) begin
        fails++;
        $display("FAIL reset inst%0d: got %h carry %b, want 0000 carry 0", s, cnt(), car());
      end
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_single();
    @(negedge clk);
    bu = 1'b1;
    @(negedge clk);
    tests++;
    if (cnt() !== 16'h0001) begin fails++; $display("FAIL single_edge1: got %h want 0001", cnt()); end
    @(negedge clk);
    tests++;
    if (cnt() !== 16'h0001) begin fails++; $display("FAIL single_edge2: got %h want 0001", cnt()); end
    bu = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_ripple();
    logic c1, c2, ok;
    for (int i = 0; i < 98; i++) press(1'b1, c1, c2);
    tests++;
    if (cnt() !== 16'h0099) begin fails++; $display("FAIL preload_99: got %h want 0099", cnt()); end
    press(1'b1, c1, c2);
    tests++;
    if (cnt() !== 16'h0100 || c1 !== 1'b0) begin fails++; $display("FAIL ripple_up: got %h carry %b want 0100 carry 0", cnt(), c1); end
    hold_to(1'b1, 16'h1000, 5000, ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL preload_1000: timeout at %h want 1000", cnt()); end
    press(1'b0, c1, c2);
    tests++;
    if (cnt() !== 16'h0999 || c1 !== 1'b0) begin fails++; $display("FAIL ripple_dn: got %h carry %b want 0999 carry 0", cnt(), c1); end
  endtask
  task automatic test_wrap();
    logic c1, c2;
    do_reset();
    press(1'b0, c1, c2);
    tests++;
    if (cnt() !== 16'h9999 || c1 !== 1'b1 || c2 !== 1'b0) begin
      fails++;
      $display("FAIL wrap_dn: got %h carry %b,%b want 9999 carry 1,0", cnt(), c1, c2);
    end
    press(1'b1, c1, c2);
    tests++;
    if (cnt() !== 16'h0000 || c1 !== 1'b1 || c2 !== 1'b0) begin
      fails++;
      $display("FAIL wrap_up: got %h carry %b,%b want 0000 carry 1,0", cnt(), c1, c2);
    end
  endtask
  task automatic test_saturate();
    logic c1, c2, ok;
    sel = 1'b1;
    do_reset();
    press(1'b0, c1, c2);
    tests++;
    if (cnt() !== 16'h0000 || c1 !== 1'b1 || c2 !== 1'b0) begin
      fails++;
      $display("FAIL sat_dn: got %h carry %b,%b want 0000 carry 1,0", cnt(), c1, c2);
    end
    hold_to(1'b1, 16'h9999, 45000, ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL preload_9999: timeout at %h want 9999", cnt()); end
    press(1'b1, c1, c2);
    tests++;
    if (cnt() !== 16'h9999 || c1 !== 1'b1 || c2 !== 1'b0) begin
      fails++;
      $display("FAIL sat_up: got %h carry %b,%b want 9999 carry 1,0", cnt(), c1, c2);
    end
    sel = 1'b0;
  endtask
  task automatic test_repeat();
    logic c1, c2;
    int   e;
    do_reset();
    @(negedge clk);
    bu = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      e = 1 + int'(k >= 9) + int'(k >= 13) + int'(k >= 17);
      tests++;
      if (cnt() !== {12'h000, e[3:0]}) begin fails++; $display("FAIL repeat_edge%0d: got %h want %0d", k, cnt(), e); end
    end
    bu = 1'b0;
    @(negedge clk);
    tests++;
    if (cnt() !== 16'h0004) begin fails++; $display("FAIL repeat_release: got %h want 0004", cnt()); end
    press(1'b1, c1, c2);
    tests++;
    if (cnt() !== 16'h0005) begin fails++; $display("FAIL repeat_repress: got %h want 0005", cnt()); end
  endtask
  task automatic test_block();
    logic c1, c2;
    do_reset();
    @(negedge clk);
    bu = 1'b1;
    bd = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (cnt() !== 16'h0000) begin fails++; $display("FAIL block_both: got %h want 0000", cnt()); end
    bd = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (cnt() !== 16'h0000) begin fails++; $display("FAIL block_up_held: got %h want 0000", cnt()); end
    bu = 1'b0;
    @(negedge clk);
    press(1'b1, c1, c2);
    tests++;
    if (cnt() !== 16'h0001) begin fails++; $display("FAIL block_exit: got %h want 0001", cnt()); end
  endtask
  task automatic test_reset_mid();
    logic c1, c2;
    do_reset();
    @(negedge clk);
    bu = 1'b1;
    repeat (12) @(negedge clk);
    tests++;
    if (cnt() !== 16'h0002) begin fails++; $display("FAIL mid_pre: got %h want 0002", cnt()); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (cnt() !== 16'h0000 || car() !== 1'b0) begin fails++; $display("FAIL mid_async: got %h carry %b want 0000 carry 0", cnt(), car()); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (cnt() !== 16'h0001) begin fails++; $display("FAIL post_reset_press: got %h want 0001", cnt()); end
    bu = 1'b0;
    @(negedge clk);
    press(1'b0, c1, c2);
    tests++;
    if (cnt() !== 16'h0000 || c1 !== 1'b0) begin fails++; $display("FAIL post_reset_dn: got %h carry %b want 0000 carry 0", cnt(), c1); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_ripple();
    test_wrap();
    test_saturate();
    test_repeat();
    test_block();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/contador_bcd_updown.md
# contador_bcd_updown

Four-digit BCD up/down counter driven by the two debounced push-buttons. Single-cycle press edges step the count; holding a button auto-repeats. It sits between the button debouncers and the 7-segment display controller: it consumes the clean button levels and drives the four BCD digits (units, tens, hundreds, thousands) that the display multiplexes.

## Interface
- HOLD_CYCLES, 50_000_000: clocks a single button must stay high after its press step before auto-repeat begins (1 s at 50 MHz).
- REPEAT_CYCLES, 10_000_000: clocks between auto-repeat steps while the button stays held (≥1).
- WRAP, 1: 1 = wrap 9999↔0000; 0 = saturate at 9999 / 0000.
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  asynchronous active-low reset.
- BtnUp  in  1  debounced level, clk-synchronous; 1 = pressed.
- BtnDown  in  1  debounced level, clk-synchronous; 1 = pressed.
- unidades  out  4  BCD units digit, 0–9.
- decenas  out  4  BCD tens digit, 0–9.
- centenas  out  4  BCD hundreds digit, 0–9.
- unidadesMillar  out  4  BCD thousands digit, 0–9.
- Carry  out  1  one-clock pulse on wrap (WRAP=1) or blocked step at a limit (WRAP=0).

## Operation
- Each button has a registered previous-sample flop; a press is BtnX=1 with previous sample 0.
- FSM states: IDLE, HOLD_UP, HOLD_DN, REPEAT_UP, REPEAT_DN, BLOCK.
- IDLE: an up press with BtnDown=0 steps +1 and goes to HOLD_UP. A down press with BtnUp=0 steps −1 and goes to HOLD_DN. Both high goes to BLOCK with no step.
- HOLD_x: the hold counter increments each clock. When it reaches HOLD_CYCLES−1, step once, clear the counter and go to REPEAT_x.
- REPEAT_x: step every REPEAT_CYCLES clocks.
- From HOLD_x or REPEAT_x: release goes to IDLE and clears the counter. The other button going high goes to BLOCK with no step.
- BLOCK: no steps until both buttons are low, then go to IDLE. A button still high on return to IDLE does not count as a press.
- Arithmetic is per-digit BCD with ripple carry/borrow. +1 on digit 9 gives 0 and carries; −1 on digit 0 gives 9 and borrows.
- Boundary rules:
  - WRAP=1: 9999+1 → 0000 and 0000−1 → 9999, each with Carry=1 for one clock.
  - WRAP=0: the count holds at the limit and Carry pulses once per blocked step.
- Digits never leave 0–9.

## Timing
- Reset (rst_n=0, asynchronous): all digits 0, Carry 0, state IDLE, hold counter 0, previous-sample flops 0. Takes effect immediately, mid-hold included.
- After rst_n deasserts, a button already high is seen as a press at the first rising edge. The previous-sample flop was reset to 0.
- Step latency: digits update at the same rising edge at which the press is sampled, so outputs are valid one clock after the button level.
- Carry is asserted in the same cycle the wrapped value appears and lasts exactly one clock.
- First auto-repeat step lands HOLD_CYCLES clocks after the press step. Subsequent steps land every REPEAT_CYCLES clocks.
- At most one step per clock.

## Test plan
Benches use HOLD_CYCLES=8, REPEAT_CYCLES=4.
- Reset and single press:
  - rst_n low, then high → digits 0,0,0,0 and Carry=0.
  - BtnUp high for 2 clocks → count 0001; exactly one step.
- BCD ripple:
  - Preload 0099 via repeated presses, then BtnUp press → 0100.
  - From 1000, BtnDown press → 0999.
- Wrap, WRAP=1:
  - From 9999, BtnUp press → 0000 with Carry high for one clock.
  - From 0000, BtnDown press → 9999 with Carry pulse.
- Saturate, WRAP=0:
  - From 9999, BtnUp press → stays 9999 with Carry pulse.
  - From 0000, BtnDown press → stays 0000 with Carry pulse.
- Auto-repeat: BtnUp held 20 clocks from 0000 → steps at clocks 0, 8, 12, 16 → final 0004. Release, then re-press → 0005.
- Simultaneous press and reset:
  - BtnUp and BtnDown rise together → no change.
  - Release BtnDown only, keeping BtnUp high → no change.
  - Release both, then press BtnUp → +1.
  - rst_n pulsed low during REPEAT_UP → 0000 immediately, state IDLE.
